// File: rtl/mdu_unit.sv
// mdu_unit: iterative multiply/divide unit with architectural HI/LO.
// Shift-add multiply and restoring divide, one step per cycle, followed by a
// one-cycle sign fixup. Raises a stall request while busy if the pipeline
// wants HI/LO or presents another MDU op.
module mdu_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             mf_read,
  input  logic             kill,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall_mdu,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  // Datapath state: {rem, quotient/dividend} for divide, {partial, multiplier} for multiply.
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;     // multiplicand (MUL) or divisor (DIV), magnitude
  logic [WIDTH-1:0]   a_raw_q;    // untouched dividend for the divide-by-zero result
  logic               is_div_q, neg_q, rneg_q;

  logic               sgn_op, accept, is_mul_op, is_div_op;
  logic [WIDTH:0]     mul_sum, div_rs, div_diff;
  logic [2*WIDTH-1:0] mul_step, div_step, prod_fix;

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + ONE_W) : v;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return cneg(v, s & v[WIDTH-1]);
  endfunction

  // Decode and one-iteration datapath for both algorithms.
  always_comb begin
    sgn_op    = ~op[0];
    accept    = (state_q == IDLE) && start && !kill;
    is_mul_op = (op == 3'd0) || (op == 3'd1);
    is_div_op = (op == 3'd2) || (op == 3'd3);
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
    div_rs    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_rs - {1'b0, opnd_q};
    div_step  = div_diff[WIDTH] ? {div_rs[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    prod_fix  = neg_q ? (~acc_q + ONE_2W) : acc_q;
  end

  // Control FSM plus HI/LO architectural registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (kill) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (start) begin
            if (is_mul_op)        state_q <= MUL;
            else if (is_div_op)   state_q <= DIV;
            else if (op == 3'd4)  hi_q    <= srcA;
            else if (op == 3'd5)  lo_q    <= srcA;
          end
        end
        MUL, DIV: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_q <= FIXUP;
        end
        FIXUP: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          if (!is_div_q) begin
            {hi_q, lo_q} <= prod_fix;
          end else if (opnd_q == '0) begin
            hi_q <= a_raw_q;
            lo_q <= '1;
          end else begin
            hi_q <= cneg(acc_q[2*WIDTH-1:WIDTH], rneg_q);
            lo_q <= cneg(acc_q[WIDTH-1:0], neg_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operand latch on accept, then one algorithm step per MUL/DIV cycle.
  always_ff @(posedge clk) begin
    if (accept && is_mul_op) begin
      acc_q    <= {{WIDTH{1'b0}}, mag(srcB, sgn_op)};
      opnd_q   <= mag(srcA, sgn_op);
      is_div_q <= 1'b0;
      neg_q    <= sgn_op & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
      rneg_q   <= 1'b0;
    end else if (accept && is_div_op) begin
      acc_q    <= {{WIDTH{1'b0}}, mag(srcA, sgn_op)};
      opnd_q   <= mag(srcB, sgn_op);
      a_raw_q  <= srcA;
      is_div_q <= 1'b1;
      neg_q    <= sgn_op & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
      rneg_q   <= sgn_op & srcA[WIDTH-1];
    end else if (state_q == MUL) begin
      acc_q <= mul_step;
    end else if (state_q == DIV) begin
      acc_q <= div_step;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state_q != IDLE);
  assign stall_mdu = busy && (mf_read || start);
  assign div_zero  = (state_q == FIXUP) && is_div_q && (opnd_q == '0) && !kill;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: hand-computed HI/LO results, latency,
// stall request, divide-by-zero pulse, kill and asynchronous reset.
module tb_mdu_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd7;
  logic [31:0] srcA = '0, srcB = '0;
  logic        mf_read = 1'b0;
  logic        kill = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, stall_mdu, div_zero;

  int total = 0;
  int bad   = 0;
  int n, dz, dzc, sbad;

  mdu_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .mf_read(mf_read), .kill(kill), .hi(hi), .lo(lo), .busy(busy),
    .stall_mdu(stall_mdu), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one op for one edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; srcA = a; srcB = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Issue an op and count busy cycles, div_zero cycles and stall misses.
  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic mf);
    issue(o, a, b);
    mf_read = mf;
    n = 0; dz = 0; dzc = 0; sbad = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      if (div_zero) begin dz++; dzc = n; end
      if (mf && !stall_mdu) sbad++;
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_stall", {31'b0, stall_mdu}, 32'd0);
    chk("rst_dz", {31'b0, div_zero}, 32'd0);
    rst = 1'b0;

    // mthi / mtlo in IDLE
    @(negedge clk);
    op = 3'd4; srcA = 32'hA5A5A5A5; start = 1'b1;
    #1 chk("mthi_stall", {31'b0, stall_mdu}, 32'd0);
    @(posedge clk); #1 start = 1'b0;
    chk("mthi_hi", hi, 32'hA5A5A5A5);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    issue(3'd5, 32'h12345678, 32'h0);
    chk("mtlo_lo", lo, 32'h12345678);
    chk("mtlo_hi_keep", hi, 32'hA5A5A5A5);

    // Reset mid-DIV
    issue(3'd3, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    chk("middiv_busy", {31'b0, busy}, 32'd1);
    chk("middiv_hi_stable", hi, 32'hA5A5A5A5);
    #1 rst = 1'b1;
    #1;
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk); rst = 1'b0;

    run(3'd0, 32'd3, 32'd4, 1'b0);
    chk("mul34_lat", n, 32'd33);
    chk("mul34_lo", lo, 32'd12);
    chk("mul34_hi", hi, 32'd0);

    run(3'd0, 32'hFFFFFFF9, 32'd6, 1'b0);
    chk("mulneg_lat", n, 32'd33);
    chk("mulneg_hi", hi, 32'hFFFFFFFF);
    chk("mulneg_lo", lo, 32'hFFFFFFD6);

    run(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
    chk("multu_hi", hi, 32'h1);
    chk("multu_lo", lo, 32'hFFFFFFFE);

    run(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("divneg_lat", n, 32'd33);
    chk("divneg_lo", lo, 32'hFFFFFFFD);
    chk("divneg_hi", hi, 32'hFFFFFFFF);

    run(3'd3, 32'd100, 32'd7, 1'b0);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    chk("divu_nodz", dz, 32'd0);

    run(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'h0);

    run(3'd3, 32'd55, 32'd0, 1'b0);
    chk("dz_hi", hi, 32'd55);
    chk("dz_lo", lo, 32'hFFFFFFFF);
    chk("dz_count", dz, 32'd1);
    chk("dz_in_fixup", dzc, 32'd33);
    chk("dz_after", {31'b0, div_zero}, 32'd0);

    // Stall request with a pending mfhi/mflo
    run(3'd1, 32'd5, 32'd5, 1'b1);
    chk("stall_lat", n, 32'd33);
    chk("stall_every_busy", sbad, 32'd0);
    chk("stall_drop", {31'b0, stall_mdu}, 32'd0);
    chk("stall_lo", lo, 32'd25);
    mf_read = 1'b0;

    // Start while busy is stalled and not accepted
    issue(3'd0, 32'd2, 32'd2);
    @(negedge clk);
    start = 1'b1; op = 3'd4; srcA = 32'hDEADBEEF;
    #1 chk("busy_start_stall", {31'b0, stall_mdu}, 32'd1);
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    chk("busy_mthi_nowrite", hi, 32'd0);
    chk("busy_mul_lo", lo, 32'd4);

    // Kill mid-DIV
    issue(3'd4, 32'd1, 32'd0);
    issue(3'd5, 32'd2, 32'd0);
    issue(3'd2, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    kill = 1'b1;
    @(posedge clk); #1 kill = 1'b0;
    chk("kill_busy", {31'b0, busy}, 32'd0);
    chk("kill_hi", hi, 32'd1);
    chk("kill_lo", lo, 32'd2);
    run(3'd0, 32'd3, 32'd4, 1'b0);
    chk("afterkill_lat", n, 32'd33);
    chk("afterkill_lo", lo, 32'd12);

    // Kill beats start in IDLE
    @(negedge clk);
    op = 3'd4; srcA = 32'd77; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1 start = 1'b0; kill = 1'b0;
    chk("killidle_hi", hi, 32'd0);
    chk("killidle_busy", {31'b0, busy}, 32'd0);

    // Reserved op ignored
    issue(3'd6, 32'd9, 32'd9);
    chk("op6_busy", {31'b0, busy}, 32'd0);
    chk("op6_lo", lo, 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers. It sits beside the execute-stage ALU.
- Multiplies and divides take multiple cycles. While they run, the unit drives a stall request back to the hazard logic, which converts it into PC/decode stalls and an execute flush.
- The unit thus initiates stalls, where the hazard logic consumes them. It also accepts mthi/mtlo writes and serves mfhi/mflo reads.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  execute-stage MDU instruction valid.
- op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, others=no-op.
- srcA  input  WIDTH  rs operand (dividend/multiplicand; mthi/mtlo data).
- srcB  input  WIDTH  rt operand (divisor/multiplier).
- mf_read  input  1  decode stage holds mfhi/mflo.
- kill  input  1  abort in-flight operation (exception/flush).
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  operation in flight.
- stall_mdu  output  1  stall request to the hazard logic.
- div_zero  output  1  one-cycle pulse when a div/divu completes with srcB=0.

Behaviour:
- Reset (async, rst=1): state=IDLE, hi=0, lo=0, busy=0, counter=0, div_zero=0. Takes effect immediately, including mid-operation.
- States:
  - IDLE, MUL, DIV, FIXUP.
  - busy=1 in MUL, DIV and FIXUP; busy=0 in IDLE.
- IDLE with start=1:
  - op 0/1: latch |A|,|B| (signed op) or raw A,B (unsigned op); record result sign = signA^signB (signed only); go to MUL with count=0.
  - op 2/3: latch operands the same way; record quotient sign = signA^signB and remainder sign = signA (signed only); go to DIV.
  - op 4: hi<=srcA at this edge; stay IDLE; busy stays 0.
  - op 5: lo<=srcA at this edge; stay IDLE; busy stays 0.
  - op 6/7: ignored.
- MUL: one shift-add step per cycle over a 2*WIDTH accumulator. count increments; after count=WIDTH-1 go to FIXUP.
- DIV: one restoring shift-subtract step per cycle (quotient and remainder). After count=WIDTH-1 go to FIXUP.
  - Divisor=0: run the full iterations anyway; the result is overridden in FIXUP.
- FIXUP (1 cycle):
  - Apply two's-complement negation per recorded sign.
  - Write {hi,lo} = product, or hi=remainder, lo=quotient.
  - Go to IDLE.
- Divide by zero: hi=srcA (unmodified dividend), lo={WIDTH{1'b1}}, and div_zero pulses in the FIXUP cycle.
- Signed overflow: -2^31 / -1 gives lo=32'h80000000, hi=0; no flag.
- Latency: start sampled at edge E0. busy is high from E0 until the edge E0+WIDTH+1, and hi/lo hold the new values after that edge. This is 33 busy cycles at WIDTH=32.
- HI/LO stability: hi/lo keep their old values throughout MUL/DIV. They change only in FIXUP or on mthi/mtlo.
- stall_mdu = busy && (mf_read || start). In-flight reads and back-to-back MDU ops therefore stall until IDLE.
  - start with busy=1 is never accepted; the op is held by the stall and re-presented.
- mthi/mtlo while busy: stall via the start term; no write.
- kill:
  - Any state -> IDLE at the next edge; hi/lo unchanged; no div_zero pulse.
  - kill has priority over FIXUP completion and over start in IDLE (no latch, no mthi/mtlo write).
- Simultaneous completion and new start:
  - In FIXUP, busy=1, so a coincident start is stalled.
  - The start is accepted the cycle after the unit reaches IDLE.

Test Plan:
- Reset mid-DIV: assert rst 10 cycles after a div start -> immediately hi=lo=0, busy=0. After release, a mult 3*4 gives lo=12, hi=0.
- Multiply sign handling:
  - mult srcA=-7 (32'hFFFFFFF9), srcB=6 -> after 33 busy cycles, hi=32'hFFFFFFFF, lo=32'hFFFFFFD6.
  - multu 32'hFFFFFFFF * 2 -> hi=1, lo=32'hFFFFFFFE.
- Divide:
  - div -7/2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
  - divu 100/7 -> lo=14, hi=2.
  - div 32'h80000000 / -1 -> lo=32'h80000000, hi=0.
- Divide by zero: divu 55/0 -> hi=55, lo=32'hFFFFFFFF, div_zero high for exactly 1 cycle in FIXUP.
- Stall request:
  - mf_read=1 asserted during MUL -> stall_mdu=1 every busy cycle; drops the cycle busy falls; hi/lo updated on that same edge.
  - mthi 32'hA5A5A5A5 while IDLE -> hi updates next edge; busy and stall_mdu stay 0.
- Kill: kill on cycle 5 of a DIV whose prior hi=1, lo=2 -> IDLE next edge, hi=1, lo=2 unchanged. A new start is accepted the following cycle.
